// File: rtl/pu_spi_slave.sv
// Purpose : SPI mode-0 slave bridging an external master to the PU data bus.
//           RX bytes are packed MSB-first into words; bus-written words are shifted out on miso.
// Latency : SPI pins pass a 2-flop synchronizer; flags <= 3 clk after a cs edge; data_out is 1 clk after signal_oe.
// Backpressure: none. Completed RX words beyond BUF_SIZE and bus writes beyond BUF_SIZE are dropped.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   signal_cycle          restart all buffer pointers, the byte counters and the partial word
//   signal_wr, data_in    append a word to the transmit buffer
//   signal_oe, data_out   pop the next receive-buffer word (0 when idle or exhausted)
//   flag_start, flag_stop one-clk pulses on cs falling / rising edges
//   mosi, miso, sclk, cs  SPI pins (cs active-low); sclk is oversampled by clk
module pu_spi_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int BUF_SIZE       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_cycle,
  input  logic                  signal_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  flag_start,
  output logic                  flag_stop,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  sclk,
  input  logic                  cs
);

  localparam int BPW = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BTW = (SPI_DATA_WIDTH > 1) ? $clog2(SPI_DATA_WIDTH) : 1;
  localparam int PW  = $clog2(BUF_SIZE + 1);
  localparam int AW  = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

  localparam logic [PW-1:0]  PTR_END   = PW'(BUF_SIZE);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
  localparam logic [BTW-1:0] BIT_LAST  = BTW'(SPI_DATA_WIDTH - 1);

  // Synchronizers are deliberately not reset: they keep tracking the pins
  // through reset so that releasing reset with cs already low cannot fake a
  // falling edge. Index [1] is the synchronized value, [2] its previous copy.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[1:0], sclk};
    cs_q   <= {cs_q[1:0], cs};
    mosi_q <= {mosi_q[0], mosi};
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];

  // Transaction is only live between a seen cs falling edge and the next
  // rising edge, so bits arriving after a mid-transaction reset are ignored.
  logic active;

  logic [DATA_WIDTH-1:0] rx_buf [BUF_SIZE];
  logic [DATA_WIDTH-1:0] tx_buf [BUF_SIZE];

  // ---------------- receive path ----------------
  logic [SPI_DATA_WIDTH-1:0] rx_shift;
  logic [BTW-1:0]            rx_bit_cnt;
  logic [BCW-1:0]            rx_byte_cnt;
  logic [DATA_WIDTH-1:0]     rx_word;
  logic [PW-1:0]             rx_wr_ptr;
  logic [PW-1:0]             rx_rd_ptr;

  logic [SPI_DATA_WIDTH-1:0] rx_byte_nx;
  logic [DATA_WIDTH-1:0]     rx_word_nx;
  logic                      rx_bit_step, rx_byte_done, rx_word_done, rx_buf_we;

  assign rx_byte_nx   = (rx_shift << 1) | SPI_DATA_WIDTH'(mosi_s);
  assign rx_word_nx   = (rx_word << SPI_DATA_WIDTH) | DATA_WIDTH'(rx_byte_nx);
  // A bit completing together with signal_cycle is dropped.
  assign rx_bit_step  = active && sclk_rise && !signal_cycle;
  assign rx_byte_done = rx_bit_step && (rx_bit_cnt == BIT_LAST);
  assign rx_word_done = rx_byte_done && (rx_byte_cnt == BYTE_LAST);
  assign rx_buf_we    = rx_word_done && (rx_wr_ptr != PTR_END);

  // Read at address 0 when signal_cycle coincides with signal_oe.
  logic [PW-1:0] rx_rd_src;
  assign rx_rd_src = signal_cycle ? '0 : rx_rd_ptr;

  // ---------------- transmit path ----------------
  logic [SPI_DATA_WIDTH-1:0] tx_shift;
  logic [BTW-1:0]            tx_bit_cnt;
  logic [BCW-1:0]            tx_byte_cnt;
  logic [PW-1:0]             tx_wr_ptr;
  logic [PW-1:0]             tx_rd_ptr;

  logic                      tx_step, tx_byte_done;
  logic [BCW-1:0]            tx_byte_nx;
  logic [PW-1:0]             tx_rd_nx;
  logic [BCW-1:0]            tx_src_byte;
  logic [PW-1:0]             tx_src_ptr;
  logic [SPI_DATA_WIDTH-1:0] tx_load;
  logic [PW-1:0]             tx_wr_addr;
  logic                      tx_buf_we;

  assign tx_step      = active && sclk_fall;
  assign tx_byte_done = tx_step && (tx_bit_cnt == BIT_LAST);

  function automatic logic [SPI_DATA_WIDTH-1:0] pick_byte(
    input logic [DATA_WIDTH-1:0] word,
    input logic [BCW-1:0]        idx
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> (SPI_DATA_WIDTH * (BPW - 1 - int'(idx)));
    return sh[SPI_DATA_WIDTH-1:0];
  endfunction

  // Position of the byte following the current one. The read pointer never
  // passes the write pointer; once drained the byte index keeps cycling and
  // zeros are sent.
  always_comb begin
    tx_byte_nx = tx_byte_cnt + BCW'(1);
    tx_rd_nx   = tx_rd_ptr;
    if (tx_byte_cnt == BYTE_LAST) begin
      tx_byte_nx = '0;
      if (tx_rd_ptr < tx_wr_ptr) tx_rd_nx = tx_rd_ptr + PW'(1);
    end
  end

  // cs falling edge reloads the current byte; a byte boundary loads the next.
  assign tx_src_ptr  = cs_fall ? tx_rd_ptr : tx_rd_nx;
  assign tx_src_byte = cs_fall ? tx_byte_cnt : tx_byte_nx;
  assign tx_load     = (tx_src_ptr < tx_wr_ptr) ?
                       pick_byte(tx_buf[tx_src_ptr[AW-1:0]], tx_src_byte) : '0;

  // signal_cycle with signal_wr writes slot 0 and leaves tx_wr_ptr at 1.
  assign tx_wr_addr = signal_cycle ? '0 : tx_wr_ptr;
  assign tx_buf_we  = signal_wr && (signal_cycle || (tx_wr_ptr != PTR_END));

  assign miso = active & tx_shift[SPI_DATA_WIDTH-1];

  // ---------------- buffers (contents survive reset) ----------------
  always_ff @(posedge clk) begin
    if (!rst && rx_buf_we) rx_buf[rx_wr_ptr[AW-1:0]] <= rx_word_nx;
    if (!rst && tx_buf_we) tx_buf[tx_wr_addr[AW-1:0]] <= data_in;
  end

  // ---------------- control state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= 1'b0;
      flag_start  <= 1'b0;
      flag_stop   <= 1'b0;
      data_out    <= '0;
      rx_shift    <= '0;
      rx_bit_cnt  <= '0;
      rx_byte_cnt <= '0;
      rx_word     <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      tx_shift    <= '0;
      tx_bit_cnt  <= '0;
      tx_byte_cnt <= '0;
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
    end else begin
      flag_start <= cs_fall;
      flag_stop  <= cs_rise;
      if (cs_fall)      active <= 1'b1;
      else if (cs_rise) active <= 1'b0;

      // receive: a partial byte is abandoned by restarting the bit count
      if (cs_fall) rx_bit_cnt <= '0;
      if (signal_cycle) begin
        rx_wr_ptr   <= '0;
        rx_byte_cnt <= '0;
        rx_word     <= '0;
      end else if (rx_bit_step) begin
        rx_shift <= rx_byte_nx;
        if (rx_byte_done) begin
          rx_bit_cnt <= '0;
          rx_word    <= rx_word_nx;
          if (rx_word_done) begin
            rx_byte_cnt <= '0;
            if (rx_wr_ptr != PTR_END) rx_wr_ptr <= rx_wr_ptr + PW'(1);
          end else begin
            rx_byte_cnt <= rx_byte_cnt + BCW'(1);
          end
        end else begin
          rx_bit_cnt <= rx_bit_cnt + BTW'(1);
        end
      end

      // bus read
      if (signal_oe) begin
        if (rx_rd_src != PTR_END) begin
          data_out  <= rx_buf[rx_rd_src[AW-1:0]];
          rx_rd_ptr <= rx_rd_src + PW'(1);
        end else begin
          data_out  <= '0;
          rx_rd_ptr <= rx_rd_src;
        end
      end else begin
        data_out <= '0;
        if (signal_cycle) rx_rd_ptr <= '0;
      end

      // bus write
      if (signal_cycle)   tx_wr_ptr <= signal_wr ? PW'(1) : '0;
      else if (tx_buf_we) tx_wr_ptr <= tx_wr_ptr + PW'(1);

      // transmit shifter
      if (cs_fall) begin
        tx_bit_cnt <= '0;
        tx_shift   <= tx_load;
      end else if (tx_byte_done) begin
        tx_bit_cnt <= '0;
        tx_shift   <= tx_load;
      end else if (tx_step) begin
        tx_bit_cnt <= tx_bit_cnt + BTW'(1);
        tx_shift   <= tx_shift << 1;
      end

      if (signal_cycle) begin
        tx_rd_ptr   <= '0;
        tx_byte_cnt <= '0;
      end else if (tx_byte_done) begin
        tx_rd_ptr   <= tx_rd_nx;
        tx_byte_cnt <= tx_byte_nx;
      end
    end
  end

endmodule

// File: tb/tb_pu_spi_slave.sv
module tb_pu_spi_slave;
  localparam int BS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signal_cycle = 1'b0;
  logic        signal_wr = 1'b0;
  logic [31:0] data_in = '0;
  logic        signal_oe = 1'b0;
  logic [31:0] data_out;
  logic        flag_start, flag_stop;
  logic        mosi = 1'b0;
  logic        miso;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;

  pu_spi_slave #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .BUF_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .signal_cycle(signal_cycle), .signal_wr(signal_wr),
    .data_in(data_in), .signal_oe(signal_oe), .data_out(data_out),
    .flag_start(flag_start), .flag_stop(flag_stop),
    .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // High cycles of each flag; equals the pulse count when every pulse is 1 clk wide.
  int n_start = 0;
  int n_stop  = 0;
  always @(negedge clk) begin
    if (flag_start) n_start++;
    if (flag_stop)  n_stop++;
  end

  // Reference model: byte stream view of the buffers.
  logic [31:0] m_rx [BS];
  int          m_wr, m_rd, m_bcnt;
  logic [31:0] m_acc;
  logic [31:0] m_tx [$];
  int          m_tk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_clear();
    m_wr = 0; m_rd = 0; m_bcnt = 0; m_acc = '0;
    m_tx.delete(); m_tk = 0;
  endtask

  task automatic m_rx_byte(input logic [7:0] b);
    m_acc = (m_acc << 8) | {24'h0, b};
    m_bcnt++;
    if (m_bcnt == 4) begin
      if (m_wr < BS) begin
        m_rx[m_wr] = m_acc;
        m_wr++;
      end
      m_bcnt = 0;
      m_acc = '0;
    end
  endtask

  task automatic cs_on();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_off();
    tick(4);
    cs = 1'b1;
    tick(6);
  endtask

  // One mode-0 byte: master samples miso just before raising sclk.
  task automatic send_byte(input logic [7:0] b);
    logic [7:0]  rb;
    logic [7:0]  exp;
    logic [31:0] w;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      tick(4);
      rb[i] = miso;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    exp = 8'h00;
    if (m_tk / 4 < m_tx.size()) begin
      w = m_tx[m_tk / 4];
      exp = 8'(w >> (8 * (3 - (m_tk % 4))));
    end
    m_tk++;
    chk("miso_byte", {24'h0, rb}, {24'h0, exp});
    m_rx_byte(b);
  endtask

  task automatic pulse_cycle();
    signal_cycle = 1'b1;
    tick(1);
    signal_cycle = 1'b0;
    m_clear();
  endtask

  task automatic bus_wr(input logic [31:0] w);
    signal_wr = 1'b1;
    data_in = w;
    tick(1);
    signal_wr = 1'b0;
    if (m_tx.size() < BS) m_tx.push_back(w);
  endtask

  task automatic bus_rd(input int n);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      signal_oe = 1'b1;
      tick(1);
      exp = (m_rd < BS) ? m_rx[m_rd] : 32'h0;
      if (m_rd < BS) m_rd++;
      chk("data_out_rd", data_out, exp);
    end
    signal_oe = 1'b0;
    tick(1);
    chk("data_out_idle", data_out, 32'h0);
  endtask

  int s0, p0;

  initial begin
    m_clear();
    tick(5);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_miso", {31'h0, miso}, 32'h0);
    chk("rst_flag_start", {31'h0, flag_start}, 32'h0);
    chk("rst_flag_stop", {31'h0, flag_stop}, 32'h0);
    rst = 1'b0;
    tick(3);

    // 28 bytes in one transaction: 7 words, the 7th is dropped
    s0 = n_start; p0 = n_stop;
    cs_on();
    for (int i = 0; i < 28; i++) send_byte(8'(i));
    cs_off();
    chk("A_start_cnt", n_start - s0, 1);
    chk("A_stop_cnt", n_stop - p0, 1);
    chk("A_model_w0", m_rx[0], 32'h00010203);
    chk("A_model_w5", m_rx[5], 32'h14151617);
    bus_rd(7);

    // four single-byte transactions assemble one word
    pulse_cycle();
    s0 = n_start; p0 = n_stop;
    for (int i = 1; i <= 4; i++) begin
      cs_on();
      send_byte(8'(i * 8'h11));
      cs_off();
    end
    chk("B_start_cnt", n_start - s0, 4);
    chk("B_stop_cnt", n_stop - p0, 4);
    chk("B_model_w0", m_rx[0], 32'h11223344);
    bus_rd(6);

    // master reads two bus-written words, then a zero byte
    pulse_cycle();
    bus_wr(32'hA1B2C3D4);
    bus_wr(32'h55667788);
    cs_on();
    for (int i = 0; i < 9; i++) send_byte(8'($urandom));
    cs_off();
    bus_rd(m_wr);

    // signal_cycle discards a partial word
    pulse_cycle();
    cs_on();
    send_byte(8'hAA);
    send_byte(8'hBB);
    cs_off();
    pulse_cycle();
    cs_on();
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    cs_off();
    chk("D_model_w0", m_rx[0], 32'h01020304);
    bus_rd(1);

    // reset in the middle of a byte, cs released while reset is held
    cs_on();
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    rst = 1'b1;
    tick(1);
    cs = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("E_rst_flag_start", {31'h0, flag_start}, 32'h0);
      chk("E_rst_flag_stop", {31'h0, flag_stop}, 32'h0);
      chk("E_rst_miso", {31'h0, miso}, 32'h0);
    end
    rst = 1'b0;
    m_clear();
    tick(3);
    s0 = n_start; p0 = n_stop;
    cs_on();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    cs_off();
    chk("E_start_cnt", n_start - s0, 1);
    chk("E_stop_cnt", n_stop - p0, 1);
    chk("E_model_w0", m_rx[0], 32'hDEADBEEF);
    bus_rd(1);

    // randomized traffic against the model
    for (int it = 0; it < 3; it++) begin
      int nw, ntr, nb;
      pulse_cycle();
      nw = int'($urandom_range(1, 7));
      for (int i = 0; i < nw; i++) bus_wr($urandom);
      ntr = int'($urandom_range(1, 4));
      s0 = n_start; p0 = n_stop;
      for (int t = 0; t < ntr; t++) begin
        nb = int'($urandom_range(1, 8));
        cs_on();
        for (int i = 0; i < nb; i++) send_byte(8'($urandom));
        cs_off();
      end
      chk("R_start_cnt", n_start - s0, ntr);
      chk("R_stop_cnt", n_stop - p0, ntr);
      bus_rd(m_wr + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_spi_slave.md
Name: pu_spi_slave

Overview:
- Processing-unit SPI slave: bridges an external SPI master to the internal PU data bus.
- Receive path: bytes arriving on mosi are packed MSB-first into DATA_WIDTH words and stored in a receive buffer of BUF_SIZE words.
- Transmit path: words written from the bus are shifted out on miso.
- Single system clock domain; the SPI pins are oversampled by that clock.

Parameters:
DATA_WIDTH, 32, width of bus words and buffer entries; must be a multiple of SPI_DATA_WIDTH
SPI_DATA_WIDTH, 8, bits per SPI byte
BUF_SIZE, 6, depth in words of both the receive and transmit buffers

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
signal_cycle  in  1  one-clk pulse; restarts all buffer pointers and the byte counter
signal_wr  in  1  write data_in into the transmit buffer
data_in  in  DATA_WIDTH  bus write data
signal_oe  in  1  read the next receive-buffer word onto data_out
data_out  out  DATA_WIDTH  bus read data; 0 when signal_oe is low
flag_start  out  1  one-clk pulse on cs falling edge (transaction start)
flag_stop  out  1  one-clk pulse on cs rising edge (transaction end)
mosi  in  1  SPI master-out
miso  out  1  SPI slave-out
sclk  in  1  SPI clock, asynchronous to clk
cs  in  1  SPI chip select, active-low

Behaviour:
- Reset values: data_out=0, miso=0, flag_start=0, flag_stop=0; all pointers and the byte/bit counters =0; buffer contents are not cleared.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- sclk, cs and mosi each pass through a 2-flop synchronizer; edges are detected on the synchronized values.
- Requirement: sclk high and low phases each >= 3 clk periods.
- Bit counter: resets on every cs falling edge.
- Byte counter and word assembly: persist across cs transactions; cleared only by rst or signal_cycle.
- Receive:
  - On a synchronized sclk rising edge with cs low, shift mosi into the byte shift register.
  - After SPI_DATA_WIDTH bits, append the byte to the word register; the first byte of a word occupies the MSBs.
  - After DATA_WIDTH/SPI_DATA_WIDTH bytes, write the word to the receive buffer at rx_wr_ptr, then increment rx_wr_ptr.
  - When rx_wr_ptr == BUF_SIZE, further completed words are dropped; no wrap-around.
  - A partial byte at cs rising edge is discarded. Partial words are kept and continue in the next transaction.
- Transmit:
  - signal_wr writes data_in at tx_wr_ptr, then increments it; saturates at BUF_SIZE.
  - Shift-out order: word tx_rd_ptr, MSB byte first, MSB bit first.
  - The first bit is presented on miso within 3 clk of the cs falling edge.
  - miso advances on each synchronized sclk falling edge.
  - After a full byte the next byte is loaded; after the last byte of a word, tx_rd_ptr increments.
  - When tx_rd_ptr >= tx_wr_ptr, miso sends 0.
  - With cs high, miso=0.
- Bus read:
  - While signal_oe=1, data_out = rx buffer[rx_rd_ptr], registered with 1-clk latency; rx_rd_ptr increments per oe cycle.
  - data_out=0 one clk after oe drops.
  - Reading at rx_rd_ptr >= BUF_SIZE returns 0.
- signal_cycle:
  - Clears rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr, the byte counter and the word register.
  - An SPI bit completing in the same clk is dropped.
  - signal_cycle during an active transaction: the transaction continues from pointer 0.
  - Simultaneous signal_wr and signal_cycle: the write goes to address 0 and tx_wr_ptr becomes 1.
- Reset mid-transaction: all state returns to reset values. The SPI slave restarts on the next cs falling edge; bits seen before it are ignored.
- flag_start and flag_stop: exactly one clk each per cs edge, delayed by the synchronizer (<= 3 clk).

Test Plan:
- Four separate 1-byte transactions 0x11, 0x22, 0x33, 0x44, then signal_oe for 1 clk -> rx buffer[0] = 0x11223344, rx buffer[1..5] unchanged, data_out=0x11223344; flag_stop pulses 4 times, flag_start 4 times.
- 28 bytes in one transaction (7 words, 0x00..0x1B) -> buffer holds 6 words (0x00010203 … 0x14151617); 7th word dropped; oe reads return those words then 0.
- signal_wr 0xA1B2C3D4 and 0x55667788, then an 8-byte master read -> master receives A1 B2 C3 D4 55 66 77 88; a following byte reads 0x00.
- Send 2 bytes 0xAA, 0xBB, pulse signal_cycle, send 0x01 0x02 0x03 0x04 -> buffer[0] = 0x01020304.
- Assert rst mid-byte, then a full 4-byte transaction 0xDE 0xAD 0xBE 0xEF -> buffer[0] = 0xDEADBEEF; flag outputs 0 during reset.
